// File: rtl/nacifra_fifo_if.sv
// Consumer-side stream of queued cipher codes.
// The FIFO drives code/valid; the consumer answers with ready.
interface nacifra_fifo_if #(
  parameter int W = 5
);
  logic [W-1:0] code;
  logic         valid;
  logic         ready;

  modport master (
    output code,
    output valid,
    input  ready
  );

  modport slave (
    input  code,
    input  valid,
    output ready
  );
endinterface

// File: rtl/nacifra_fifo.sv
// Cipher-code capture stage: syncs the encoder strobe, drops error codes,
// and queues valid codes in a first-word-fall-through FIFO.
module nacifra_fifo #(
  parameter int         DEPTH    = 8,
  parameter logic [4:0] ERR_CODE = 5'd14,
  parameter int         ERR_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [4:0]               code_in,
  input  logic                     code_rdy,
  nacifra_fifo_if.master           out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [ERR_W-1:0]         err_cnt,
  output logic                     overflow,
  input  logic                     clr_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [2:0]    rdy_sync;
  logic          rdy_rise;
  logic          cap_vld;
  logic [4:0]    cap_code;
  logic          is_err;
  logic          req;
  logic          push;
  logic          pop;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    mem [DEPTH];

  // [0],[1] form the synchroniser; [2] is the edge-detect history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_sync <= '0;
    end else begin
      rdy_sync <= {rdy_sync[1:0], code_rdy};
    end
  end

  assign rdy_rise = rdy_sync[1] & ~rdy_sync[2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_vld  <= 1'b0;
      cap_code <= '0;
    end else begin
      cap_vld <= rdy_rise;
      if (rdy_rise) begin
        cap_code <= code_in;
      end
    end
  end

  assign is_err = cap_vld & (cap_code == ERR_CODE);
  assign req    = cap_vld & ~is_err;
  assign pop    = out.valid & out.ready;
  assign push   = req & (~full | pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cap_code;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      unique case (1'b1)
        push & ~pop: count <= count + CW'(1);
        pop & ~push: count <= count - CW'(1);
        default:     count <= count;
      endcase
    end
  end

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign out.valid = ~empty;
  assign out.code  = out.valid ? mem[rd_ptr] : 5'd0;

  // clear takes priority over a same-cycle drop or error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (clr_flags) begin
      overflow <= 1'b0;
    end else if (req & full & ~pop) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt <= '0;
    end else if (clr_flags) begin
      err_cnt <= '0;
    end else if (is_err & ~(&err_cnt)) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_nacifra_fifo.sv
// Self-checking bench for nacifra_fifo: directed scenarios plus random
// pulse/pop/clear traffic compared against a queue-based model.
module tb_nacifra_fifo;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] code_in = 5'd0;
  logic       code_rdy = 1'b0;
  logic       clr_flags = 1'b0;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic [7:0] err_cnt;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  logic [4:0] mq[$];
  int         m_err = 0;
  bit         m_ovf = 0;

  nacifra_fifo_if ifc ();

  nacifra_fifo dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .code_in   (code_in),
    .code_rdy  (code_rdy),
    .out       (ifc),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .err_cnt   (err_cnt),
    .overflow  (overflow),
    .clr_flags (clr_flags)
  );

  always #5 clk = ~clk;

  function automatic void model_pulse(input logic [4:0] c, input bit pop);
    if (pop && mq.size() > 0) void'(mq.pop_front());
    if (c == 5'd14) begin
      if (m_err < 255) m_err++;
    end else if (mq.size() < 8) begin
      mq.push_back(c);
    end else begin
      m_ovf = 1;
    end
  endfunction

  // Full strobe cycle; optional one-cycle ready aligned with the push edge.
  task automatic pulse(input logic [4:0] c, input bit pop,
                       output logic [4:0] head);
    @(negedge clk);
    code_in = c;
    code_rdy = 1'b1;
    repeat (3) @(negedge clk);
    head = ifc.code;
    code_rdy = 1'b0;
    ifc.ready = pop;
    @(negedge clk);
    ifc.ready = 1'b0;
    repeat (2) @(negedge clk);
    model_pulse(c, pop);
  endtask

  task automatic pop_one(output logic [4:0] head);
    @(negedge clk);
    head = ifc.code;
    ifc.ready = 1'b1;
    @(negedge clk);
    ifc.ready = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic clear_flags();
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    m_err = 0;
    m_ovf = 0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (ifc.valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || ifc.code !== 5'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b e=%b f=%b c=%0d want 0 1 0 0",
               ifc.valid, empty, full, ifc.code);
    end
    checks++;
    if (count !== 4'd0 || err_cnt !== 8'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got cnt=%0d err=%0d ovf=%b want 0 0 0",
               count, err_cnt, overflow);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency();
    logic [4:0] h;
    @(negedge clk);
    code_in = 5'b10000;
    code_rdy = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (ifc.valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: got valid=%b want 0", ifc.valid);
    end
    code_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (ifc.valid !== 1'b1 || ifc.code !== 5'd16 || count !== 4'd1) begin
      errors++;
      $display("FAIL latency_4: got v=%b c=%0d cnt=%0d want 1 16 1",
               ifc.valid, ifc.code, count);
    end
    mq.push_back(5'd16);
    repeat (3) @(negedge clk);
    checks++;
    if (ifc.code !== 5'd16) begin
      errors++;
      $display("FAIL stall_hold: got %0d want 16", ifc.code);
    end
    pop_one(h);
    checks++;
    if (empty !== 1'b1 || ifc.code !== 5'd0 || h !== 5'd16) begin
      errors++;
      $display("FAIL latency_pop: got e=%b c=%0d h=%0d want 1 0 16", empty, ifc.code, h);
    end
  endtask

  task automatic test_hold();
    logic [4:0] h;
    @(negedge clk);
    code_in = 5'd7;
    code_rdy = 1'b1;
    repeat (20) @(negedge clk);
    code_rdy = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (count !== 4'd1 || ifc.code !== 5'd7) begin
      errors++;
      $display("FAIL hold_once: got cnt=%0d c=%0d want 1 7", count, ifc.code);
    end
    mq.push_back(5'd7);
    pop_one(h);
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL hold_drain: got empty=%b want 1", empty);
    end
  endtask

  task automatic test_errors();
    logic [4:0] h;
    for (int i = 0; i < 3; i++) pulse(5'd14, 1'b0, h);
    checks++;
    if (count !== 4'd0 || err_cnt !== 8'd3) begin
      errors++;
      $display("FAIL err_count: got cnt=%0d err=%0d want 0 3", count, err_cnt);
    end
    clear_flags();
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL err_clear: got %0d want 0", err_cnt);
    end
  endtask

  task automatic test_overflow();
    logic [4:0] h;
    for (int i = 1; i <= 9; i++) pulse(5'(i), 1'b0, h);
    checks++;
    if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_full: got f=%b cnt=%0d ovf=%b want 1 8 1", full, count, overflow);
    end
    for (int i = 1; i <= 8; i++) begin
      pop_one(h);
      checks++;
      if (h !== 5'(i)) begin
        errors++;
        $display("FAIL ovf_order: got %0d want %0d", h, i);
      end
    end
    checks++;
    if (empty !== 1'b1 || ifc.valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_empty: got e=%b v=%b want 1 0", empty, ifc.valid);
    end
  endtask

  task automatic test_full_passthrough();
    logic [4:0] h;
    logic [4:0] exp[$];
    for (int i = 0; i < 8; i++) pulse(5'(i + 20), 1'b0, h);
    pulse(5'd21, 1'b1, h);
    checks++;
    if (h !== 5'd20 || count !== 4'd8 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL pass_full: got h=%0d cnt=%0d ovf=%b want 20 8 1", h, count, overflow);
    end
    exp = mq;
    for (int i = 0; i < 8; i++) begin
      pop_one(h);
      checks++;
      if (h !== exp[i]) begin
        errors++;
        $display("FAIL pass_order%0d: got %0d want %0d", i, h, exp[i]);
      end
    end
    clear_flags();
    checks++;
    if (overflow !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL pass_clear: got ovf=%b e=%b want 0 1", overflow, empty);
    end
  endtask

  task automatic test_err_saturate();
    logic [4:0] h;
    for (int i = 0; i < 258; i++) pulse(5'd14, 1'b0, h);
    checks++;
    if (err_cnt !== 8'(m_err) || err_cnt !== 8'hff) begin
      errors++;
      $display("FAIL err_sat: got %0d want 255", err_cnt);
    end
    clear_flags();
  endtask

  task automatic test_random();
    logic [4:0] h;
    logic [4:0] c;
    logic [4:0] want;
    bit p;
    for (int it = 0; it < 120; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        c = ($urandom_range(0, 4) == 0) ? 5'd14 : 5'($urandom_range(0, 31));
        p = ($urandom_range(0, 3) == 0);
        want = (mq.size() > 0) ? mq[0] : 5'd0;
        pulse(c, p, h);
        checks++;
        if (p && h !== want) begin
          errors++;
          $display("FAIL rnd_pp%0d: got %0d want %0d", it, h, want);
        end
      end else if (op <= 8) begin
        want = (mq.size() > 0) ? mq[0] : 5'd0;
        pop_one(h);
        checks++;
        if (h !== want) begin
          errors++;
          $display("FAIL rnd_pop%0d: got %0d want %0d", it, h, want);
        end
      end else begin
        clear_flags();
      end
      want = (mq.size() > 0) ? mq[0] : 5'd0;
      checks++;
      if (count !== 4'(mq.size()) || full !== (mq.size() == 8) ||
          empty !== (mq.size() == 0) || ifc.valid !== (mq.size() != 0)) begin
        errors++;
        $display("FAIL rnd_occ%0d: got cnt=%0d f=%b e=%b want cnt=%0d",
                 it, count, full, empty, mq.size());
      end
      checks++;
      if (ifc.code !== want || err_cnt !== 8'(m_err) || overflow !== m_ovf) begin
        errors++;
        $display("FAIL rnd_st%0d: got c=%0d err=%0d ovf=%b want %0d %0d %b",
                 it, ifc.code, err_cnt, overflow, want, m_err, m_ovf);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] h;
    while (mq.size() > 0) pop_one(h);
    for (int i = 0; i < 5; i++) pulse(5'(i + 1), 1'b0, h);
    checks++;
    if (count !== 4'd5) begin
      errors++;
      $display("FAIL ar_pre: got %0d want 5", count);
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0 || ifc.valid !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL ar_async: got cnt=%0d v=%b e=%b want 0 0 1", count, ifc.valid, empty);
    end
    mq.delete();
    m_err = 0;
    m_ovf = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    pulse(5'd3, 1'b0, h);
    checks++;
    if (ifc.code !== 5'd3 || count !== 4'd1) begin
      errors++;
      $display("FAIL ar_post: got c=%0d cnt=%0d want 3 1", ifc.code, count);
    end
  endtask

  initial begin
    ifc.ready = 1'b0;
    test_reset();
    test_latency();
    test_hold();
    test_errors();
    test_overflow();
    test_full_passthrough();
    test_err_saturate();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
